// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared UART constants: TX FSM encoding and frame format codes.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam int UART_BAUD_W = 13;

    localparam logic [2:0] UART_TX_IDLE   = 3'd0;
    localparam logic [2:0] UART_TX_START  = 3'd1;
    localparam logic [2:0] UART_TX_DATA   = 3'd2;
    localparam logic [2:0] UART_TX_PARITY = 3'd3;
    localparam logic [2:0] UART_TX_STOP   = 3'd4;

    localparam logic DATA_BITS_7 = 1'b0;
    localparam logic DATA_BITS_8 = 1'b1;
    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = UART_TX_IDLE,
        ST_START  = UART_TX_START,
        ST_DATA   = UART_TX_DATA,
        ST_PARITY = UART_TX_PARITY,
        ST_STOP   = UART_TX_STOP
    } uart_tx_state_e;

    // Index of the final data bit for the selected character length.
    function automatic logic [2:0] uart_last_bit(input logic data_bits);
        return (data_bits == DATA_BITS_7) ? 3'd6 : 3'd7;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Register-block to TX-engine bus: write strobe, config, status.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic                   tx_data_reg_wr;
    logic [7:0]             tx_data;
    logic [UART_BAUD_W-1:0] baud_val;
    logic                   data_bits;
    logic                   parity_en;
    logic                   parity_odd0_even1;
    logic                   tx_ready;
    logic                   tx_idle;
    logic                   tx_overflow;
    logic                   txd;

    modport master (
        output tx_data_reg_wr, tx_data, baud_val, data_bits, parity_en, parity_odd0_even1,
        input  tx_ready, tx_idle, tx_overflow, txd
    );

    modport slave (
        input  tx_data_reg_wr, tx_data, baud_val, data_bits, parity_en, parity_odd0_even1,
        output tx_ready, tx_idle, tx_overflow, txd
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous FIFO; writes when full and reads when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_wr,
    input  wire logic [7:0]    i_wdata,
    input  wire logic          i_rd,
    output logic      [7:0]    o_rdata,
    output logic      [AW:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam logic [AW:0] c_COUNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == c_COUNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_wr && !o_full;
    assign w_pop   = i_rd && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmit engine: 4-entry byte FIFO feeding a frame serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  wire logic ACLK,
    input  wire logic ARESET,
    uart_tx_if.slave  bus
);

    logic [7:0]             w_fifo_rdata;
    logic [FIFO_AW:0]       w_fifo_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [FIFO_AW:0]       w_cnt_nx;

    uart_tx_state_e         r_state, w_state_nx;
    logic [UART_BAUD_W-1:0] r_baud_cnt, w_baud_cnt_nx;
    logic [2:0]             r_bit_cnt, w_bit_cnt_nx;
    logic [7:0]             r_shift, w_shift_nx;
    logic                   r_par, w_par_nx;
    logic                   r_db, w_db_nx;
    logic                   r_pen, w_pen_nx;
    logic                   r_peven, w_peven_nx;
    logic                   w_bit_end;
    logic                   w_txd;
    logic                   r_txd;
    logic                   r_idle;
    logic                   r_ovf;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .i_wr    (bus.tx_data_reg_wr),
        .i_wdata (bus.tx_data),
        .i_rd    (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_push    = bus.tx_data_reg_wr && !w_fifo_full;
    assign w_bit_end = (r_baud_cnt == '0);

    always_comb begin
        w_cnt_nx = w_fifo_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nx = w_fifo_count + 1'b1;
            2'b01:   w_cnt_nx = w_fifo_count - 1'b1;
            default: w_cnt_nx = w_fifo_count;
        endcase
    end

    always_comb begin
        w_state_nx    = r_state;
        w_baud_cnt_nx = r_baud_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        w_par_nx      = r_par;
        w_db_nx       = r_db;
        w_pen_nx      = r_pen;
        w_peven_nx    = r_peven;
        w_pop         = 1'b0;
        w_txd         = 1'b1;

        // baud_val is re-read at every reload, so it is never frame-latched.
        if (r_state != ST_IDLE) begin
            w_baud_cnt_nx = w_bit_end ? bus.baud_val : r_baud_cnt - 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nx    = w_fifo_rdata;
                    w_db_nx       = bus.data_bits;
                    w_pen_nx      = bus.parity_en;
                    w_peven_nx    = bus.parity_odd0_even1;
                    w_par_nx      = 1'b0;
                    w_bit_cnt_nx  = 3'd0;
                    w_baud_cnt_nx = bus.baud_val;
                    w_state_nx    = ST_START;
                end
            end
            ST_START: begin
                w_txd = 1'b0;
                if (w_bit_end) w_state_nx = ST_DATA;
            end
            ST_DATA: begin
                w_txd = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nx = r_shift >> 1;
                    w_par_nx   = r_par ^ r_shift[0];
                    if (r_bit_cnt == uart_last_bit(r_db)) begin
                        w_state_nx = r_pen ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                w_txd = (r_peven == PARITY_EVEN) ? r_par : ~r_par;
                if (w_bit_end) w_state_nx = ST_STOP;
            end
            ST_STOP: begin
                w_txd = 1'b1;
                if (w_bit_end) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_db       <= DATA_BITS_8;
            r_pen      <= 1'b0;
            r_peven    <= PARITY_EVEN;
            r_txd      <= 1'b1;
            r_idle     <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            r_par      <= w_par_nx;
            r_db       <= w_db_nx;
            r_pen      <= w_pen_nx;
            r_peven    <= w_peven_nx;
            r_txd      <= w_txd;
            r_idle     <= (w_state_nx == ST_IDLE) && (w_cnt_nx == '0);
            r_ovf      <= bus.tx_data_reg_wr && w_fifo_full;
        end
    end

    assign bus.tx_ready    = !w_fifo_full;
    assign bus.tx_idle     = r_idle;
    assign bus.tx_overflow = r_ovf;
    assign bus.txd         = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx: frame table, corner sequences, random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int FIFO_DEPTH = 4;

    logic ACLK = 1'b0;
    logic ARESET;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_if bus ();

    uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (2)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;

    // Reference model: pending bytes, and the line samples still owed for the current frame.
    logic [7:0] m_fifo [$];
    bit         m_line [$];
    logic       e_txd, e_ready, e_idle, e_ovf;

    typedef struct {
        logic [7:0]  data;
        logic [12:0] baud;
        logic        db;
        logic        pen;
        logic        peven;
        int          nbits;
        logic [11:0] line;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic [12:0] baud,
                              input logic db, input logic pen, input logic peven);
        int         len;
        int         n;
        logic [7:0] m;
        bit         p;
        len = int'(baud) + 1;
        n   = db ? 8 : 7;
        m   = db ? d : {1'b0, d[6:0]};
        for (int k = 0; k < len; k++) m_line.push_back(1'b0);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < len; k++) m_line.push_back(m[i]);
        if (pen) begin
            p = (($countones(m) % 2) == 1) ^ !peven;
            for (int k = 0; k < len; k++) m_line.push_back(p);
        end
        for (int k = 0; k < len; k++) m_line.push_back(1'b1);
    endtask

    // Advance one clock: predict from pre-edge inputs, then compare all outputs.
    task automatic tick();
        bit         idle_pre;
        bit         do_pop;
        logic [7:0] b;
        if (ARESET) begin
            m_fifo.delete();
            m_line.delete();
            e_txd = 1'b1; e_ready = 1'b1; e_idle = 1'b1; e_ovf = 1'b0;
        end else begin
            idle_pre = (m_line.size() == 0);
            do_pop   = idle_pre && (m_fifo.size() != 0);
            e_ovf    = bus.tx_data_reg_wr && (m_fifo.size() == FIFO_DEPTH);
            if (idle_pre) e_txd = 1'b1;
            else          e_txd = m_line.pop_front();
            if (do_pop) begin
                b = m_fifo.pop_front();
                push_frame(b, bus.baud_val, bus.data_bits, bus.parity_en, bus.parity_odd0_even1);
            end
            if (bus.tx_data_reg_wr && !e_ovf) m_fifo.push_back(bus.tx_data);
            e_ready = (m_fifo.size() != FIFO_DEPTH);
            e_idle  = (m_line.size() == 0) && (m_fifo.size() == 0);
        end
        @(posedge ACLK);
        #1;
        chk("model_txd",      bus.txd,         e_txd);
        chk("model_ready",    bus.tx_ready,    e_ready);
        chk("model_idle",     bus.tx_idle,     e_idle);
        chk("model_overflow", bus.tx_overflow, e_ovf);
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (!bus.tx_idle && i < budget) begin
            tick();
            i++;
        end
        chk("drain_in_budget", bus.tx_idle, 1'b1);
    endtask

    task automatic set_cfg(input logic [12:0] baud, input logic db, input logic pen, input logic peven);
        bus.baud_val          = baud;
        bus.data_bits         = db;
        bus.parity_en         = pen;
        bus.parity_odd0_even1 = peven;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.tx_data_reg_wr = 1'b1;
        bus.tx_data        = d;
        tick();
        bus.tx_data_reg_wr = 1'b0;
    endtask

    initial begin
        int len;
        int guard;

        // line[i] is the i-th bit on the wire: start, data LSB-first, parity, stop.
        vecs[0] = '{8'hA5, 13'd3, 1'b1, 1'b0, 1'b0, 10, 12'b0011_0100_1010};
        vecs[1] = '{8'h83, 13'd0, 1'b0, 1'b1, 1'b1, 10, 12'b0010_0000_0110};
        vecs[2] = '{8'h83, 13'd0, 1'b0, 1'b1, 1'b0, 10, 12'b0011_0000_0110};
        vecs[3] = '{8'h00, 13'd2, 1'b1, 1'b1, 1'b0, 11, 12'b0110_0000_0000};
        vecs[4] = '{8'hFF, 13'd1, 1'b0, 1'b0, 1'b1,  9, 12'b0001_1111_1110};
        vecs[5] = '{8'h5A, 13'd0, 1'b1, 1'b1, 1'b1, 11, 12'b0100_1011_0100};

        ARESET             = 1'b1;
        bus.tx_data_reg_wr = 1'b0;
        bus.tx_data        = 8'h00;
        set_cfg(13'd3, 1'b1, 1'b0, 1'b1);

        repeat (3) tick();
        chk("reset_txd",      bus.txd,         1'b1);
        chk("reset_ready",    bus.tx_ready,    1'b1);
        chk("reset_idle",     bus.tx_idle,     1'b1);
        chk("reset_overflow", bus.tx_overflow, 1'b0);
        ARESET = 1'b0;
        tick();

        // Hand-written frame table.
        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].baud, vecs[v].db, vecs[v].pen, vecs[v].peven);
            write_byte(vecs[v].data);
            tick();
            chk("tbl_pre_start", bus.txd, 1'b1);
            len = int'(vecs[v].baud) + 1;
            for (int bi = 0; bi < vecs[v].nbits; bi++)
                for (int c = 0; c < len; c++) begin
                    tick();
                    chk("tbl_bit", bus.txd, vecs[v].line[bi]);
                end
            drain(10);
        end

        // Reset in the middle of a frame discards the frame and the queue.
        set_cfg(13'd3, 1'b1, 1'b0, 1'b1);
        write_byte(8'h00);
        write_byte(8'h00);
        repeat (10) tick();
        ARESET = 1'b1;
        tick();
        chk("midreset_txd",   bus.txd,      1'b1);
        chk("midreset_idle",  bus.tx_idle,  1'b1);
        chk("midreset_ready", bus.tx_ready, 1'b1);
        ARESET = 1'b0;
        repeat (30) tick();
        chk("midreset_stays_idle", bus.tx_idle, 1'b1);

        // Burst of six writes: five accepted, the sixth overflows.
        set_cfg(13'd1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            write_byte(8'h10 + 8'(k));
            if (k == 4) chk("burst_full_not_ready", bus.tx_ready, 1'b0);
            if (k == 5) chk("burst_overflow_pulse", bus.tx_overflow, 1'b1);
        end
        tick();
        chk("burst_overflow_clears", bus.tx_overflow, 1'b0);
        drain(200);

        // Config change mid-frame applies only to the next frame.
        set_cfg(13'd1, 1'b1, 1'b0, 1'b1);
        write_byte(8'hC3);
        write_byte(8'h3C);
        repeat (6) tick();
        set_cfg(13'd1, 1'b0, 1'b1, 1'b1);
        drain(200);

        // Write while full on the very cycle the FSM pops.
        set_cfg(13'd0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) write_byte(8'h60 + 8'(k));
        guard = 0;
        while (!(m_line.size() == 0 && m_fifo.size() == FIFO_DEPTH) && guard < 200) begin
            tick();
            guard++;
        end
        chk("fullpop_reached", bus.tx_ready, 1'b0);
        write_byte(8'hEE);
        chk("fullpop_overflow", bus.tx_overflow, 1'b1);
        chk("fullpop_ready",    bus.tx_ready,    1'b1);
        drain(300);

        // Randomised traffic against the reference model.
        for (int batch = 0; batch < 4; batch++) begin
            set_cfg(13'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
            for (int c = 0; c < 300; c++) begin
                bus.tx_data_reg_wr = ($urandom_range(0, 3) == 0);
                bus.tx_data        = 8'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    bus.data_bits         = 1'($urandom);
                    bus.parity_en         = 1'($urandom);
                    bus.parity_odd0_even1 = 1'($urandom);
                end
                tick();
            end
            bus.tx_data_reg_wr = 1'b0;
            drain(500);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
